// File: rtl/ats_gen2.sv
// ats_gen2: bank of free-running counters plus compare alarms, configured through
// a three-phase (IDLE/EXEC/RESP) req/ready command port with per-command status.
module ats_gen2 #(
    parameter int CLOCK_WIDTH = 16,
    parameter int NUM_CLOCKS  = 16,
    parameter int NUM_ALARMS  = 24,
    parameter int FIRE_CYCLES = 2,
    parameter int CLK_BITS    = $clog2(NUM_CLOCKS),
    parameter int IDX_W       = $clog2((NUM_CLOCKS > NUM_ALARMS) ? NUM_CLOCKS : NUM_ALARMS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [2:0]             op,
    input  logic [IDX_W-1:0]       idx,
    input  logic [CLOCK_WIDTH-1:0] value,
    input  logic [CLK_BITS:0]      aux,
    output logic                   ready,
    output logic [1:0]             stat,
    output logic [CLOCK_WIDTH-1:0] rd_data,
    output logic [NUM_ALARMS-1:0]  data
);

    localparam int FC_W = $clog2(FIRE_CYCLES + 1);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_EN   = 3'b010;
    localparam logic [2:0] OP_READ = 3'b011;
    localparam logic [2:0] OP_SET  = 3'b100;
    localparam logic [2:0] OP_DIS  = 3'b101;

    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_ERR_IDX = 2'b10;
    localparam logic [1:0] ST_ERR_OP  = 2'b11;

    localparam logic [IDX_W:0]    N_CLK_I = (IDX_W + 1)'(NUM_CLOCKS);
    localparam logic [IDX_W:0]    N_ALM_I = (IDX_W + 1)'(NUM_ALARMS);
    localparam logic [CLK_BITS:0] N_CLK_S = (CLK_BITS + 1)'(NUM_CLOCKS);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t state_q, state_d;

    logic [2:0]             op_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CLOCK_WIDTH-1:0] value_q;
    logic [CLK_BITS:0]      aux_q;

    logic [CLOCK_WIDTH-1:0] count [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0]  clk_en;

    logic [CLOCK_WIDTH-1:0] alm_tgt  [NUM_ALARMS];
    logic [CLK_BITS-1:0]    alm_sel  [NUM_ALARMS];
    logic [FC_W-1:0]        fire_cnt [NUM_ALARMS];
    logic [CLOCK_WIDTH-1:0] alm_cnt  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]  alm_loop, alm_en, alm_armed;
    logic [NUM_ALARMS-1:0]  on_tgt, match, set_hit, dis_hit;

    logic                   clk_op, alm_op, cmd_ok;
    logic [1:0]             resp_stat;
    logic [CLOCK_WIDTH-1:0] rd_sel;

    // Command FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are only consumed in EXEC, so they need no reset
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req) begin
            op_q    <= op;
            idx_q   <= idx;
            value_q <= value;
            aux_q   <= aux;
        end
    end

    // Validate the captured command
    always_comb begin
        clk_op = (op_q == OP_LOAD) || (op_q == OP_EN) || (op_q == OP_READ);
        alm_op = (op_q == OP_SET) || (op_q == OP_DIS);
        if (op_q[2:1] == 2'b11)
            resp_stat = ST_ERR_OP;
        else if ((clk_op && ({1'b0, idx_q} >= N_CLK_I)) ||
                 (alm_op && ({1'b0, idx_q} >= N_ALM_I)) ||
                 ((op_q == OP_SET) && ({1'b0, aux_q[CLK_BITS-1:0]} >= N_CLK_S)))
            resp_stat = ST_ERR_IDX;
        else
            resp_stat = ST_OK;
        cmd_ok = (state_q == S_EXEC) && (resp_stat == ST_OK);

        rd_sel = '0;
        for (int j = 0; j < NUM_CLOCKS; j++)
            if (idx_q == IDX_W'(j)) rd_sel = count[j];
    end

    // Response is registered at the EXEC edge and lives for the RESP cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat    <= 2'b00;
            rd_data <= '0;
        end else if (state_q == S_EXEC) begin
            stat    <= resp_stat;
            rd_data <= (resp_stat == ST_OK && op_q == OP_READ) ? rd_sel : '0;
        end else begin
            stat    <= 2'b00;
            rd_data <= '0;
        end
    end

    // Clock bank: a load beats the increment; enable changes take effect next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NUM_CLOCKS; j++) count[j] <= '0;
            clk_en <= '0;
        end else begin
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                if (cmd_ok && op_q == OP_LOAD && idx_q == IDX_W'(j))
                    count[j] <= value_q;
                else if (clk_en[j])
                    count[j] <= count[j] + CLOCK_WIDTH'(1);
                if (cmd_ok && op_q == OP_EN && idx_q == IDX_W'(j))
                    clk_en[j] <= value_q[0];
            end
        end
    end

    // Alarm compare against the selected clock's current count
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alm_cnt[i] = '0;
            for (int j = 0; j < NUM_CLOCKS; j++)
                if (alm_sel[i] == CLK_BITS'(j)) alm_cnt[i] = count[j];
            on_tgt[i]  = (alm_cnt[i] == alm_tgt[i]);
            match[i]   = alm_en[i] && alm_armed[i] && on_tgt[i];
            set_hit[i] = cmd_ok && (op_q == OP_SET) && (idx_q == IDX_W'(i));
            dis_hit[i] = cmd_ok && (op_q == OP_DIS) && (idx_q == IDX_W'(i));
            data[i]    = (fire_cnt[i] != '0);
        end
    end

    // Commands override a same-cycle match; a match reloads the pulse window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_tgt[i]  <= '0;
                alm_sel[i]  <= '0;
                fire_cnt[i] <= '0;
            end
            alm_loop  <= '0;
            alm_en    <= '0;
            alm_armed <= '1;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (set_hit[i]) begin
                    alm_tgt[i]   <= value_q;
                    alm_sel[i]   <= aux_q[CLK_BITS-1:0];
                    alm_loop[i]  <= aux_q[CLK_BITS];
                    alm_en[i]    <= 1'b1;
                    alm_armed[i] <= 1'b1;
                    fire_cnt[i]  <= '0;
                end else if (dis_hit[i]) begin
                    alm_en[i]   <= 1'b0;
                    fire_cnt[i] <= '0;
                    if (!on_tgt[i]) alm_armed[i] <= 1'b1;
                end else if (match[i]) begin
                    fire_cnt[i]  <= FC_W'(FIRE_CYCLES);
                    alm_armed[i] <= 1'b0;
                    if (!alm_loop[i]) alm_en[i] <= 1'b0;
                end else begin
                    if (!on_tgt[i]) alm_armed[i] <= 1'b1;
                    if (fire_cnt[i] != '0) fire_cnt[i] <= fire_cnt[i] - FC_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/ats_gen2.md
Name: ats_gen2

Overview:
Second-generation alarm timer system: a bank of NUM_CLOCKS free-running counters and NUM_ALARMS compare alarms, configured through a req/ready command port.
- Each alarm watches one selectable clock, fires a FIRE_CYCLES-wide pulse on its data bit, and is either one-shot or looping.
- Adds over the first generation: full parametrisation, clock load/read, loop mode, and per-command status/error reporting.
- Sits in the timer subsystem; data feeds the interrupt aggregator.

Parameters:
CLOCK_WIDTH, 16, counter and alarm compare width
NUM_CLOCKS, 16, number of base clocks (>=2)
NUM_ALARMS, 24, number of alarms (>=1)
FIRE_CYCLES, 2, cycles an alarm's data bit stays high per fire (>=1)
CLK_BITS, $clog2(NUM_CLOCKS), clock-select width (derived)
IDX_W, $clog2(max(NUM_CLOCKS,NUM_ALARMS)), command index width (derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  1  command request
op  in  3  command opcode
idx  in  IDX_W  clock or alarm index
value  in  CLOCK_WIDTH  command operand
aux  in  CLK_BITS+1  ALM_SET only: [CLK_BITS-1:0] clock select, [CLK_BITS] loop
ready  out  1  command port idle, req accepted when high
stat  out  2  response status, valid in RESP cycle only
rd_data  out  CLOCK_WIDTH  read result, valid in RESP cycle
data  out  NUM_ALARMS  per-alarm fire pulse

Behaviour:
Reset (reset low, async):
- All counts 0; all clocks and alarms disabled; armed 1.
- Outputs: data 0, ready 1, stat 00, rd_data 0; FSM goes to IDLE.

Command FSM:
- IDLE: ready=1. Accepts when req&&ready; op/idx/value/aux are captured at that edge.
- EXEC: ready=0. Validates and applies the command.
- RESP: ready=0. stat and rd_data are valid for exactly this cycle. Next state is IDLE.
- Latency: accept at edge T, update visible after edge T+1, RESP during T+1..T+2, ready high again after T+2.
- req while ready=0 is ignored.

stat encoding:
- 01 OK.
- 10 ERR_INDEX: idx out of range for the op class, or ALM_SET clock select >= NUM_CLOCKS.
- 11 ERR_OPCODE: op 110 or 111.
- 00 outside RESP.
- Any error makes no state change and returns rd_data 0.

Opcodes:
- 000 NOP: OK.
- 001 CLK_LOAD: count[idx] <= value. Takes priority over that clock's increment in the same cycle.
- 010 CLK_EN: enable[idx] <= value[0]. Count is held while disabled.
- 011 CLK_READ: rd_data <= count[idx], sampled in EXEC.
- 100 ALM_SET: target <= value, sel <= aux clock select, loop <= aux[CLK_BITS], enable 1, armed 1, fire counter cleared, data bit cleared.
- 101 ALM_DIS: enable 0, data bit and fire counter cleared.
- Clock ops (001-011) require idx < NUM_CLOCKS. Alarm ops (100-101) require idx < NUM_ALARMS.

Clocks:
- Enabled clock increments by 1 every cycle.
- Wraps from 2^CLOCK_WIDTH-1 to 0 with no flag.

Alarms (evaluated every cycle, all in parallel):
- match = enable && armed && count[sel]==target.
- On match:
  - data bit goes high from the next cycle for FIRE_CYCLES cycles;
  - armed <= 0;
  - if loop=0, enable <= 0.
- armed <= 1 whenever count[sel] != target. A stopped clock sitting on target therefore fires once only.
- A looping alarm re-fires each wrap period. A match during an active pulse restarts the FIRE_CYCLES window.
- ALM_SET whose target equals the current count fires in the cycle after EXEC.
- ALM_DIS/ALM_SET in the same cycle as a match: the command wins, so no pulse.
- Multiple alarms on one clock fire independently in the same cycle.

Reset mid-command: abort, return to IDLE, apply all reset values.

Test Plan:
- Reset then idle 5 cycles -> data 0, ready 1, stat 00; CLK_READ idx 3 -> rd_data 0, stat 01 in RESP, ready low exactly 2 cycles.
- CLK_LOAD c0=10, CLK_EN c0=1, ALM_SET a5 value 20 sel 0 loop 0 -> data[5] high exactly 2 cycles once, count passes 20 again after wrap with no fire, alarm reads disabled.
- CLOCK_WIDTH=4 build: c1 enabled, a0 loop=1 target 3 on c1 -> data[0] pulses every 16 cycles, 2 cycles wide; ALM_DIS a0 mid-pulse -> data[0] drops the cycle after EXEC.
- CLK_EN c2=0 with count 7, ALM_SET a1 target 7 sel 2 -> single 2-cycle pulse, no repeat while count stays 7; CLK_LOAD c2=7 again -> still no fire (not re-armed).
- Errors: CLK_LOAD idx 16 (NUM_CLOCKS=16) -> stat 10, no count changes; op 111 -> stat 11; ALM_SET aux clock select 16 with CLK_BITS=5 build and NUM_CLOCKS=17 -> stat 01, select 17 -> stat 10.
- Assert reset during EXEC of CLK_LOAD c0=99 -> c0 reads 0 after release, ready 1 immediately after reset deassertion, data 0.
